// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// 8N1 UART receiver feeding a small show-ahead receive FIFO. The serial line is
// synchronised, framed by a five-state receiver (IDLE/START/DATA/STOP/BREAK),
// and complete bytes are pushed into a circular buffer that the host pops one
// entry at a time. A line held low produces a single framing error and is then
// parked in BREAK until it returns high, so it never yields phantom bytes.
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency
//   BAUD_RATE    line rate; CLK_FREQ_HZ / BAUD_RATE must be at least 8
//   FIFO_DEPTH   entry count; power of 2, at least 2
//
// Ports
//   CLK         system clock, rising edge
//   RESET       asynchronous active-high reset
//   RXD         asynchronous serial input, idle high
//   rd_en       pop the head entry (ignored while the FIFO is empty)
//   err_clr     clear frame_err and overrun (a simultaneous set wins)
//   rd_data     head entry of the FIFO (show-ahead)
//   rx_valid    FIFO not empty
//   fifo_count  FIFO occupancy
//   frame_err   sticky: a stop bit was sampled low
//   overrun     sticky: a received byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RXD,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  // The baud counter counts down to zero; loading N-1 makes the next expiry
  // land exactly N cycles later.
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to the idle level so a reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM: state register
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              baud_tick;

  assign baud_tick = (baud_cnt == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational block assigns a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (!rxs) state_next = S_START;
      S_START: if (baud_tick) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (baud_tick && (bit_cnt == 3'd7)) state_next = S_STOP;
      S_STOP:  if (baud_tick) state_next = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM: output / control strobes
  // ---------------------------------------------------------------------------
  logic load_half;   // falling edge seen in IDLE: aim at the middle of start
  logic load_full;   // start confirmed or data bit taken: wait one bit time
  logic shift_en;    // sample a data bit into the shift register
  logic push_byte;   // good stop bit: hand the byte to the FIFO
  logic frame_set;   // bad stop bit

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    push_byte = 1'b0;
    frame_set = 1'b0;
    unique case (state)
      S_IDLE:  load_half = !rxs;
      S_START: load_full = baud_tick && !rxs;
      S_DATA: begin
        load_full = baud_tick;
        shift_en  = baud_tick;
      end
      S_STOP: begin
        push_byte = baud_tick && rxs;
        frame_set = baud_tick && !rxs;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver datapath: baud counter, bit counter, shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (load_half)          baud_cnt <= HALF_LOAD;
      else if (load_full)     baud_cnt <= FULL_LOAD;
      else if (!baud_tick)    baud_cnt <= baud_cnt - BAUD_W'(1);

      // Bit 7 wraps the counter back to 0, ready for the next frame.
      if (load_half)          bit_cnt <= '0;
      else if (shift_en)      bit_cnt <= bit_cnt + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (shift_en)           shift_reg <= {rxs, shift_reg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_pop;
  logic             do_push;
  logic             drop_byte;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign do_pop     = rd_en && !fifo_empty;
  // When full, a same-cycle pop frees the head slot, which is the slot the
  // write pointer already points at, so the push can still be accepted.
  assign do_push    = push_byte && (!fifo_full || do_pop);
  assign drop_byte  = push_byte && fifo_full && !do_pop;

  // NOTE: the storage array is reset because it is only a handful of bytes
  // and rd_data must read back as zero after reset; deeper buffers would
  // normally leave the RAM unreset and gate the output instead.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a set event on the same cycle as err_clr wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (drop_byte)    overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  assign rd_data    = mem[rd_ptr];
  assign rx_valid   = !fifo_empty;
  assign fifo_count = count;

endmodule
